// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter driving open-drain clock/data requests.
// Optional PS2_TX_RESEND_EN: one automatic retry of the latched byte after a device NACK.
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE      | lines released, tx_ready high
// INHIBIT   | host holds clock low; data pulled low on the last count
// START     | clock and data both low, request-to-send
// SEND      | device clocks out data, parity and stop bits
// ACK       | waiting for the device ACK/NACK clock
// WAIT_IDLE | waiting for clock and data both released
module ps2_host_tx #(
  parameter int CLK_FREQ   = 28_000_000,
  parameter int INHIBIT_US = 120,
  parameter int TIMEOUT_MS = 15
) (
  input  logic       clk28,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_out,
  output logic       ps2_dat_out,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       timeout
);
  localparam int INH_CYC = CLK_FREQ / 1_000_000 * INHIBIT_US;
  localparam int TO_CYC  = CLK_FREQ / 1000 * TIMEOUT_MS;
  localparam int INH_W   = $clog2(INH_CYC + 1);
  localparam int TO_W    = $clog2(TO_CYC + 1);
  localparam logic [INH_W-1:0] INH_LOAD = INH_W'(INH_CYC - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_START, S_SEND, S_ACK, S_WAIT_IDLE
  } state_t;

  state_t           state_q, state_d;
  logic [9:0]       frame_q, frame_d;
  logic [3:0]       bitcnt_q, bitcnt_d;
  logic [INH_W-1:0] inh_q, inh_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic             nack_q, nack_d;
  logic             clk_out_d, dat_out_d, done_d, err_d, tmo_d;
  logic [1:0]       clk_sync, dat_sync;
  logic             clk_prev;
  logic             fe, counting, accept;
`ifdef PS2_TX_RESEND_EN
  logic             retried_q, retried_d;
`endif

  assign fe       = clk_prev & ~clk_sync[1];
  assign tx_ready = rst_n && (state_q == S_IDLE);
  assign busy     = (state_q != S_IDLE);
  assign accept   = tx_valid && tx_ready;
  assign counting = (state_q == S_SEND) || (state_q == S_ACK) || (state_q == S_WAIT_IDLE);

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk_in};
      dat_sync <= {dat_sync[0], ps2_dat_in};
      clk_prev <= clk_sync[1];
    end
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      frame_q     <= '0;
      bitcnt_q    <= '0;
      inh_q       <= '0;
      to_q        <= '0;
      nack_q      <= 1'b0;
      ps2_clk_out <= 1'b1;
      ps2_dat_out <= 1'b1;
      done        <= 1'b0;
      err         <= 1'b0;
      timeout     <= 1'b0;
`ifdef PS2_TX_RESEND_EN
      retried_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      bitcnt_q    <= bitcnt_d;
      inh_q       <= inh_d;
      to_q        <= to_d;
      nack_q      <= nack_d;
      ps2_clk_out <= clk_out_d;
      ps2_dat_out <= dat_out_d;
      done        <= done_d;
      err         <= err_d;
      timeout     <= tmo_d;
`ifdef PS2_TX_RESEND_EN
      retried_q   <= retried_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    bitcnt_d  = bitcnt_q;
    inh_d     = inh_q;
    to_d      = to_q;
    nack_d    = nack_q;
    clk_out_d = ps2_clk_out;
    dat_out_d = ps2_dat_out;
    done_d    = 1'b0;
    err_d     = 1'b0;
    tmo_d     = 1'b0;
`ifdef PS2_TX_RESEND_EN
    retried_d = retried_q;
`endif
    if (counting) to_d = fe ? '0 : to_q + TO_W'(1);

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          frame_d   = {1'b1, ~^tx_data, tx_data};
          bitcnt_d  = '0;
          inh_d     = INH_LOAD;
          clk_out_d = 1'b0;
          state_d   = S_INHIBIT;
`ifdef PS2_TX_RESEND_EN
          retried_d = 1'b0;
`endif
        end
      end
      S_INHIBIT: begin
        if (inh_q == INH_W'(1)) dat_out_d = 1'b0;
        if (inh_q == '0) state_d = S_START;
        else inh_d = inh_q - INH_W'(1);
      end
      S_START: begin
        clk_out_d = 1'b1;
        to_d      = '0;
        state_d   = S_SEND;
      end
      S_SEND: begin
        if (fe) begin
          dat_out_d = frame_q[bitcnt_q];
          bitcnt_d  = bitcnt_q + 4'd1;
          if (bitcnt_q == 4'd9) state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (fe) begin
          nack_d  = dat_sync[1];
          state_d = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (clk_sync[1] && dat_sync[1]) begin
`ifdef PS2_TX_RESEND_EN
          if (nack_q && !retried_q) begin
            retried_d = 1'b1;
            bitcnt_d  = '0;
            inh_d     = INH_LOAD;
            clk_out_d = 1'b0;
            state_d   = S_INHIBIT;
          end else begin
            done_d  = 1'b1;
            err_d   = nack_q;
            state_d = S_IDLE;
          end
`else
          done_d  = 1'b1;
          err_d   = nack_q;
          state_d = S_IDLE;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A stalled device aborts the whole transfer, including any pending retry.
    if (counting && to_q == TO_LAST) begin
      clk_out_d = 1'b1;
      dat_out_d = 1'b1;
      done_d    = 1'b1;
      err_d     = 1'b1;
      tmo_d     = 1'b1;
      to_d      = '0;
      state_d   = S_IDLE;
    end
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: behavioural PS/2 device on the merged bus plus a
// scoreboard of expected frame/err/timeout per accepted byte.
module tb_ps2_host_tx;
  localparam int CLK_FREQ   = 1_000_000;
  localparam int INHIBIT_US = 120;
  localparam int TIMEOUT_MS = 15;
  localparam int INH_CYC    = 120;
  localparam int TO_CYC     = 15000;
  localparam int HALF       = 20;

  logic       clk28 = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_out, ps2_dat_out, busy, done, err, timeout;
  logic       dev_clk = 1'b1, dev_dat = 1'b1;
  logic       bus_clk, bus_dat;

  assign bus_clk = ps2_clk_out & dev_clk;
  assign bus_dat = ps2_dat_out & dev_dat;

  ps2_host_tx #(.CLK_FREQ(CLK_FREQ), .INHIBIT_US(INHIBIT_US), .TIMEOUT_MS(TIMEOUT_MS)) u_dut (
    .clk28(clk28), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ps2_clk_in(bus_clk), .ps2_dat_in(bus_dat), .ps2_clk_out(ps2_clk_out), .ps2_dat_out(ps2_dat_out),
    .busy(busy), .done(done), .err(err), .timeout(timeout));

  always #5 clk28 = ~clk28;

  typedef struct packed { logic [7:0] data; logic err; logic tmo; } exp_t;
  exp_t exp_q[$];
  int n_chk = 0, n_err = 0;
  int done_cnt = 0, acc_cnt = 0;

  always @(posedge clk28) begin
    if (done) done_cnt <= done_cnt + 1;
    if (tx_valid && tx_ready) acc_cnt <= acc_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // start bit, data LSB first, odd parity, stop
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic par;
    par = ($countones(b) % 2) == 0;
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic send_req(input logic [7:0] b, input logic e, input logic t);
    int n;
    exp_q.push_back('{b, e, t});
    tx_data  = b;
    tx_valid = 1'b1;
    n = 0;
    while (!tx_ready && n < 100) begin @(negedge clk28); n++; end
    @(posedge clk28);
    @(negedge clk28);
    tx_valid = 1'b0;
    chk("busy_rise", {31'd0, busy}, 1);
  endtask

  task automatic dev_xfer(input logic nack, input logic no_clock, input int abort_fe);
    int n, clk_low, dat_lead;
    logic [10:0] bits;
    logic glitch;
    n = 0; clk_low = 0; dat_lead = 0; bits = '0; glitch = 1'b0;
    while (ps2_clk_out && n < 200) begin @(negedge clk28); n++; end
    chk("inhibit_seen", {31'd0, ps2_clk_out}, 0);
    while (!ps2_clk_out && clk_low < INH_CYC + 50) begin
      if (!ps2_dat_out) dat_lead++;
      clk_low++;
      @(negedge clk28);
    end
    // inhibit window plus the single START cycle
    chk("inhibit_len", clk_low, INH_CYC + 1);
    chk("start_lead", dat_lead, 2);
    bits[0] = bus_dat;
    if (no_clock) return;
    repeat (HALF) @(negedge clk28);
    for (int i = 1; i <= 11; i++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk28);
      if (i == abort_fe) return;
      dev_clk = 1'b1;
      if (i <= 10) bits[i] = bus_dat;
      glitch |= !ps2_clk_out;
      if (i == 10) begin
        repeat (HALF / 2) @(negedge clk28);
        dev_dat = nack;
        repeat (HALF - HALF / 2) @(negedge clk28);
      end else if (i == 11) begin
        dev_dat = 1'b1;
      end else begin
        repeat (HALF) @(negedge clk28);
      end
    end
    chk("frame_bits", {21'd0, bits}, {21'd0, frame_of(exp_q[0].data)});
    chk("clk_not_driven", {31'd0, glitch}, 0);
  endtask

  task automatic wait_done(input int limit, output int cyc);
    exp_t e;
    cyc = 0;
    while (!done && cyc < limit) begin @(negedge clk28); cyc++; end
    chk("done_seen", {31'd0, done}, 1);
    e = exp_q.pop_front();
    if (done) begin
      chk("err", {31'd0, err}, {31'd0, e.err});
      chk("timeout", {31'd0, timeout}, {31'd0, e.tmo});
      chk("busy_drop", {31'd0, busy}, 0);
      chk("lines_released", {30'd0, ps2_clk_out, ps2_dat_out}, 3);
    end
  endtask

  initial begin
    int cyc, d0, a0;
    repeat (3) @(negedge clk28);
    chk("rst_clk_out", {31'd0, ps2_clk_out}, 1);
    chk("rst_dat_out", {31'd0, ps2_dat_out}, 1);
    chk("rst_ready", {31'd0, tx_ready}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_flags", {29'd0, done, err, timeout}, 0);
    rst_n = 1'b1;
    @(negedge clk28);
    chk("ready_after_rst", {31'd0, tx_ready}, 1);

    send_req(8'hED, 1'b0, 1'b0); dev_xfer(1'b0, 1'b0, 0); wait_done(200, cyc);
    send_req(8'h07, 1'b0, 1'b0); dev_xfer(1'b0, 1'b0, 0); wait_done(200, cyc);
    send_req(8'h00, 1'b0, 1'b0); dev_xfer(1'b0, 1'b0, 0); wait_done(200, cyc);

`ifdef PS2_TX_RESEND_EN
    send_req(8'h3C, 1'b0, 1'b0);
    d0 = done_cnt;
    dev_xfer(1'b1, 1'b0, 0);
    dev_xfer(1'b0, 1'b0, 0);
    chk("no_done_on_retry", done_cnt, d0);
    chk("busy_across_retry", {31'd0, busy}, 1);
    wait_done(200, cyc);
`else
    send_req(8'h3C, 1'b1, 1'b0); dev_xfer(1'b1, 1'b0, 0); wait_done(200, cyc);
`endif

    send_req(8'hF3, 1'b1, 1'b1); dev_xfer(1'b0, 1'b1, 0);
    wait_done(TO_CYC + 100, cyc);
    chk("timeout_cycles", cyc, TO_CYC);
    @(negedge clk28);
    chk("ready_after_timeout", {31'd0, tx_ready}, 1);

    send_req(8'hED, 1'b0, 1'b0); dev_xfer(1'b0, 1'b0, 5);
    chk("bit4_driven_low", {31'd0, ps2_dat_out}, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_lines", {30'd0, ps2_clk_out, ps2_dat_out}, 3);
    chk("async_rst_busy", {31'd0, busy}, 0);
    void'(exp_q.pop_front());
    @(negedge clk28);
    dev_clk = 1'b1; dev_dat = 1'b1;
    @(negedge clk28);
    rst_n = 1'b1;
    repeat (4) @(negedge clk28);
    send_req(8'hFF, 1'b0, 1'b0); dev_xfer(1'b0, 1'b0, 0); wait_done(200, cyc);

    exp_q.push_back('{8'hA5, 1'b0, 1'b0});
    exp_q.push_back('{8'hA5, 1'b0, 1'b0});
    a0 = acc_cnt;
    tx_data = 8'hA5;
    tx_valid = 1'b1;
    dev_xfer(1'b0, 1'b0, 0);
    wait_done(200, cyc);
    chk("single_accept", acc_cnt - a0, 1);
    @(negedge clk28);
    chk("second_accept", acc_cnt - a0, 2);
    tx_valid = 1'b0;
    dev_xfer(1'b0, 1'b0, 0);
    wait_done(200, cyc);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
